sand_pixel_fetch: RTL and testbench

SAND_PIXEL_FETCH -- requirements
Module: sand_pixel_fetch

---
 rtl/sand_pixel_fetch.sv | 217 +++++++++++++++++++++
 tb/tb_sand_pixel_fetch.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sand_pixel_fetch.sv
// sand_pixel_fetch: framebuffer and pixel fetch for a 160x120 grid of falling-sand cells.
//
// Host side (Avalon slave):
//   chipselect, write, read  - bus strobes
//   address[15]=0            - cell index in [14:0] (row*160+col); writes store writedata[1:0]
//   address[15]=1            - register [3:0]: 0..11 palette {R,G,B} per type, 15 = clearing
//   readdata                 - registered, valid one cycle after chipselect&&read
// Display side:
//   hcount, vcount, blank_n_in, hs_in, vs_in - from the VGA timing counters
//   VGA_R/G/B, VGA_BLANK_n, VGA_HS, VGA_VS   - aligned 3 clk behind the timing inputs
// clk is the 50 MHz system clock; reset is synchronous, active low.
// After reset the grid is swept to type 0, one cell per cycle, before host cell writes
// are accepted.
// Optional macro SAND_GRID_EN: overlay a 20/20/20 grid line on active pixels.
module sand_pixel_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [15:0] address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        blank_n_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_BLANK_n,
    output logic        VGA_HS,
    output logic        VGA_VS
);

    localparam int unsigned NumCells = 19200;
    localparam int unsigned NumPal   = 12;
    localparam logic [14:0] CellLimit = 15'd19200;
    localparam logic [14:0] LastCell  = 15'd19199;
    localparam logic [7:0]  PalReset [NumPal] = '{
        8'h00, 8'h00, 8'h00,
        8'hC2, 8'hB2, 8'h80,
        8'h80, 8'h80, 8'h80,
        8'h20, 8'h40, 8'hE0
    };

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e      state_q, state_d;
    logic [14:0] clr_cnt_q, clr_cnt_d;
    logic        clearing;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            StClear: begin
                if (clr_cnt_q == LastCell) begin
                    state_d = StRun;
                end else begin
                    clr_cnt_d = clr_cnt_q + 15'd1;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    assign clearing = (state_q == StClear);

    // Cell RAM: one write port shared by the clear sweep and the host, one display read port.
    logic [1:0]  mem [NumCells];
    logic        host_cell_we;
    logic        ram_we;
    logic [14:0] ram_waddr;
    logic [1:0]  ram_wdata;

    assign host_cell_we = chipselect && write && !address[15] && (address[14:0] < CellLimit);
    assign ram_we       = clearing || host_cell_we;
    assign ram_waddr    = clearing ? clr_cnt_q : address[14:0];
    assign ram_wdata    = clearing ? 2'd0 : writedata[1:0];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    // Palette registers.
    logic [7:0] pal_q [NumPal];
    logic       pal_we;

    assign pal_we = chipselect && write && address[15] && (address[3:0] < 4'd12);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NumPal; i++) begin
                pal_q[i] <= PalReset[i];
            end
        end else if (pal_we) begin
            pal_q[address[3:0]] <= writedata;
        end
    end

    // Register read path.
    logic [7:0] rd_val;

    always_comb begin
        rd_val = 8'h00;
        if (address[15]) begin
            if (address[3:0] < 4'd12) begin
                rd_val = pal_q[address[3:0]];
            end else if (address[3:0] == 4'd15) begin
                rd_val = {7'b0, clearing};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            readdata <= 8'h00;
        end else if (chipselect && read) begin
            readdata <= rd_val;
        end
    end

    // Display pipeline: S0 index, S1 RAM read, S2 palette lookup.
    logic [14:0] pix_idx_q;
    logic [1:0]  cell_q;
    logic [2:0]  blank_sr_q, hs_sr_q, vs_sr_q;
    logic [3:0]  pal_base;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_idx_q  <= '0;
            blank_sr_q <= 3'b000;
            hs_sr_q    <= 3'b111;
            vs_sr_q    <= 3'b111;
        end else begin
            pix_idx_q  <= ({7'd0, vcount[9:2]} * 15'd160) + {7'd0, hcount[10:3]};
            blank_sr_q <= {blank_sr_q[1:0], blank_n_in};
            hs_sr_q    <= {hs_sr_q[1:0], hs_in};
            vs_sr_q    <= {vs_sr_q[1:0], vs_in};
        end
    end

    // During the clear sweep the RAM holds stale cells, so the display shows type 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cell_q <= 2'd0;
        end else if (clearing || (pix_idx_q >= CellLimit)) begin
            cell_q <= 2'd0;
        end else begin
            cell_q <= mem[pix_idx_q];
        end
    end

    assign pal_base = {2'b00, cell_q} + {1'b0, cell_q, 1'b0};

`ifdef SAND_GRID_EN
    logic [1:0] grid_sr_q;
    logic       unused_hbit;

    assign unused_hbit = hcount[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            grid_sr_q <= 2'b00;
        end else begin
            grid_sr_q <= {grid_sr_q[0], (hcount[2:1] == 2'd0) || (vcount[1:0] == 2'd0)};
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{hcount[2:0], vcount[1:0]};
`endif

    // blank_sr_q[1] is the blank bit of the pixel being looked up this cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            VGA_R <= 8'h00;
            VGA_G <= 8'h00;
            VGA_B <= 8'h00;
        end else if (!blank_sr_q[1]) begin
            VGA_R <= 8'h00;
            VGA_G <= 8'h00;
            VGA_B <= 8'h00;
`ifdef SAND_GRID_EN
        end else if (grid_sr_q[1]) begin
            VGA_R <= 8'h20;
            VGA_G <= 8'h20;
            VGA_B <= 8'h20;
`endif
        end else begin
            VGA_R <= pal_q[pal_base];
            VGA_G <= pal_q[pal_base + 4'd1];
            VGA_B <= pal_q[pal_base + 4'd2];
        end
    end

    assign VGA_BLANK_n = blank_sr_q[2];
    assign VGA_HS      = hs_sr_q[2];
    assign VGA_VS      = vs_sr_q[2];

endmodule

// File: tb/tb_sand_pixel_fetch.sv
// Testbench for sand_pixel_fetch: display expectations are queued when pixels are driven
// and compared against the output history once their 3-cycle latency has elapsed.
module tb_sand_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [15:0] address = '0;
    logic [7:0]  writedata = '0;
    logic [7:0]  readdata;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        blank_n_in = 1'b0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_BLANK_n, VGA_HS, VGA_VS;

    sand_pixel_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .hcount      (hcount),
        .vcount      (vcount),
        .blank_n_in  (blank_n_in),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_BLANK_n (VGA_BLANK_n),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output history, one entry per cycle: {blank, hs, vs, r, g, b}.
    logic [26:0] hist [256];
    always @(negedge clk) hist[cyc % 256] = {VGA_BLANK_n, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B};

    typedef struct {
        int          due;
        logic [26:0] exp;
        string       name;
    } pix_t;

    pix_t sb[$];

    // Reference model.
    logic [1:0] grid [19200];
    logic [7:0] pal [12];
    bit         model_clearing = 1'b1;

    task automatic set_pal_defaults();
        pal = '{8'h00, 8'h00, 8'h00, 8'hC2, 8'hB2, 8'h80,
                8'h80, 8'h80, 8'h80, 8'h20, 8'h40, 8'hE0};
    endtask

    function automatic logic [26:0] exp_pix(int h, int v, bit b, bit hs, bit vs);
        int          idx;
        logic [1:0]  t;
        logic [23:0] rgb;
        idx = (v / 4) * 160 + (h / 8);
        t   = (model_clearing || idx >= 19200) ? 2'd0 : grid[idx];
        rgb = {pal[t * 3], pal[t * 3 + 1], pal[t * 3 + 2]};
`ifdef SAND_GRID_EN
        if (((h / 2) % 4 == 0) || (v % 4 == 0)) rgb = 24'h202020;
`endif
        if (!b) rgb = 24'h0;
        return {b, hs, vs, rgb};
    endfunction

    // Drive one pixel in the current cycle (caller is at a negedge) and queue its expectation.
    task automatic pix(input int h, input int v, input bit b, input bit hs, input bit vs,
                       input string nm);
        pix_t e;
        hcount     = 11'(h);
        vcount     = 10'(v);
        blank_n_in = b;
        hs_in      = hs;
        vs_in      = vs;
        e.due  = cyc + 3;
        e.exp  = exp_pix(h, v, b, hs, vs);
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic host_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    // Returns at the negedge where readdata holds the result.
    task automatic host_rd(input logic [15:0] a);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic test_reset();
        // Non-idle inputs during reset so the reset values are distinguishable.
        reset = 1'b0; blank_n_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
        hcount = 11'd8; vcount = 10'd4;
        chipselect = 1'b1; read = 1'b1; address = 16'h8003;
        repeat (4) @(negedge clk);
        checks++;
        if (readdata !== 8'h00) begin
            errors++; $display("FAIL reset_readdata: got %h expected 00", readdata);
        end
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
            errors++; $display("FAIL reset_rgb: got %h expected 000000", {VGA_R, VGA_G, VGA_B});
        end
        checks++;
        if ({VGA_BLANK_n, VGA_HS, VGA_VS} !== 3'b011) begin
            errors++;
            $display("FAIL reset_sync: got %b expected 011", {VGA_BLANK_n, VGA_HS, VGA_VS});
        end
        blank_n_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic test_clear_timing();
        @(negedge clk);
        reset = 1'b1; chipselect = 1'b1; read = 1'b1; address = 16'h800F;
        for (int n = 1; n <= 19201; n++) begin
            @(negedge clk);
            if (n == 1 || n == 19200 || n == 19201) begin
                checks++;
                if (readdata !== {7'b0, n <= 19200}) begin
                    errors++;
                    $display("FAIL clear_flag_n%0d: got %h expected %h", n, readdata,
                             {7'b0, n <= 19200});
                end
            end
        end
        chipselect = 1'b0; read = 1'b0;
        model_clearing = 1'b0;
    endtask

    task automatic test_palette_reset();
        for (int r = 0; r < 16; r++) begin
            logic [7:0] e;
            e = (r < 12) ? pal[r] : 8'h00;
            host_rd(16'h8000 | 16'(r));
            checks++;
            if (readdata !== e) begin
                errors++; $display("FAIL pal_reset_r%0d: got %h expected %h", r, readdata, e);
            end
        end
        host_rd(16'h8005);
        repeat (2) @(negedge clk);
        checks++;
        if (readdata !== 8'h80) begin
            errors++; $display("FAIL readdata_hold: got %h expected 80", readdata);
        end
        host_rd(16'd100);
        checks++;
        if (readdata !== 8'h00) begin
            errors++; $display("FAIL cell_read_zero: got %h expected 00", readdata);
        end
    endtask

    task automatic test_cell_write();
        pix_t e;
        host_wr(16'd161, 8'h01); grid[161] = 2'd1;
        host_wr(16'd162, 8'hFF); grid[162] = 2'd3;
        host_wr(16'd320, 8'h02); grid[320] = 2'd2;
        @(negedge clk); pix(8, 4, 1, 1, 1, "cell161_t1");
        @(negedge clk); pix(0, 0, 1, 1, 1, "cell0_t0");
        @(negedge clk); pix(16, 4, 1, 1, 1, "cell162_t3");
        @(negedge clk); pix(0, 8, 1, 1, 1, "cell320_t2");
        @(negedge clk); pix(15, 7, 1, 1, 1, "cell161_corner");
        @(negedge clk); pix(0, 5, 1, 1, 1, "cell160_grid");
        @(negedge clk); pix(0, 0, 0, 1, 1, "idle");
        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (hist[e.due % 256] !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, hist[e.due % 256], e.exp);
            end
        end
    endtask

    task automatic test_palette_rw();
        pix_t e;
        host_wr(16'h8009, 8'hFF); pal[9] = 8'hFF;
        for (int r = 9; r <= 11; r++) begin
            host_rd(16'h8000 | 16'(r));
            checks++;
            if (readdata !== pal[r]) begin
                errors++; $display("FAIL pal_rd_r%0d: got %h expected %h", r, readdata, pal[r]);
            end
        end
        @(negedge clk); pix(16, 4, 1, 1, 1, "cell162_newpal");
        @(negedge clk); pix(0, 0, 0, 1, 1, "idle");
        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (hist[e.due % 256] !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, hist[e.due % 256], e.exp);
            end
        end
    endtask

    task automatic test_invalid_writes();
        pix_t e;
        host_wr(16'd19200, 8'h03);
        host_wr(16'h800C, 8'h55);
        host_wr(16'h800F, 8'h01);
        host_rd(16'h800C);
        checks++;
        if (readdata !== 8'h00) begin
            errors++; $display("FAIL reg12_ignored: got %h expected 00", readdata);
        end
        host_rd(16'h800F);
        checks++;
        if (readdata !== 8'h00) begin
            errors++; $display("FAIL reg15_ignored: got %h expected 00", readdata);
        end
        @(negedge clk); pix(0, 0, 1, 1, 1, "cell0_after_oob");
        @(negedge clk); pix(1272, 476, 1, 1, 1, "cell19199_after_oob");
        @(negedge clk); pix(0, 0, 0, 1, 1, "idle");
        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (hist[e.due % 256] !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, hist[e.due % 256], e.exp);
            end
        end
    endtask

    task automatic test_sync_pulses();
        pix_t e;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pix(8, 4, (i != 0) && (i != 4) && (i != 7), i != 2, i != 6,
                $sformatf("sync_step%0d", i));
        end
        @(negedge clk); pix(0, 0, 0, 1, 1, "idle");
        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (hist[e.due % 256] !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, hist[e.due % 256], e.exp);
            end
        end
    endtask

    task automatic test_collision();
        pix_t e;
        // Host write lands on the same cycle the first pixel reads the RAM.
        @(negedge clk); pix(8, 4, 1, 1, 1, "coll_ram_old");
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 16'd161; writedata = 8'h02;
        grid[161] = 2'd2;
        pix(8, 4, 1, 1, 1, "coll_ram_new");
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        pix(8, 4, 1, 1, 1, "coll_pal_old");
        // Palette write lands on the same cycle "coll_pal_old" is looked up.
        @(negedge clk);
        pal[6] = 8'h33;
        pix(8, 4, 1, 1, 1, "coll_pal_new");
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 16'h8006; writedata = 8'h33;
        pix(0, 0, 0, 1, 1, "idle");
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (hist[e.due % 256] !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, hist[e.due % 256], e.exp);
            end
        end
    endtask

    task automatic test_restart();
        pix_t e;
        bit   done;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clearing = 1'b1;
        set_pal_defaults();
        for (int i = 0; i < 19200; i++) grid[i] = 2'd0;
        // Cell 161 still holds type 2 in RAM; display must show type 0.
        pix(8, 4, 1, 1, 1, "clear_cell161");
        @(negedge clk); pix(16, 4, 1, 1, 1, "clear_cell162");
        @(negedge clk); pix(0, 0, 0, 1, 1, "idle");
        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (hist[e.due % 256] !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, hist[e.due % 256], e.exp);
            end
        end
        host_rd(16'h8009);
        checks++;
        if (readdata !== 8'h20) begin
            errors++; $display("FAIL restart_pal9: got %h expected 20", readdata);
        end
        host_rd(16'h800F);
        checks++;
        if (readdata !== 8'h01) begin
            errors++; $display("FAIL restart_clearing: got %h expected 01", readdata);
        end
        host_wr(16'h8003, 8'h11); pal[3] = 8'h11;
        repeat (200) @(negedge clk);
        host_wr(16'd5, 8'h02);  // sweep already passed cell 5; write must be dropped
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 16'h800F;
        done = 1'b0;
        for (int n = 0; n < 20000 && !done; n++) begin
            @(negedge clk);
            if (readdata === 8'h00) done = 1'b1;
        end
        chipselect = 1'b0; read = 1'b0;
        checks++;
        if (!done) begin
            errors++; $display("FAIL restart_clear_done: got timeout expected clearing=0");
        end
        model_clearing = 1'b0;
        host_wr(16'd161, 8'h01); grid[161] = 2'd1;
        @(negedge clk); pix(40, 0, 1, 1, 1, "dropped_cell5");
        @(negedge clk); pix(8, 4, 1, 1, 1, "cell161_pal_in_clear");
        @(negedge clk); pix(16, 4, 1, 1, 1, "cell162_cleared");
        @(negedge clk); pix(0, 0, 0, 1, 1, "idle");
        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (hist[e.due % 256] !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, hist[e.due % 256], e.exp);
            end
        end
    endtask

    initial begin
        set_pal_defaults();
        for (int i = 0; i < 19200; i++) grid[i] = 2'd0;
        test_reset();
        test_clear_timing();
        test_palette_reset();
        test_cell_write();
        test_palette_rw();
        test_invalid_writes();
        test_sync_pulses();
        test_collision();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
